// File: rtl/branch_ctrl.sv
// branch_ctrl: execute-stage branch/jump resolution controller.
// Captures one branch at a time, resolves outcome and target in a single
// COMPARE cycle, then holds a redirect toward fetch until it is accepted.
// Optional macro BRANCH_PREDICT_EN adds a 32-entry 2-bit counter table that
// feeds fetch predictions and suppresses redirects for correct predictions.
module branch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [2:0]  in_funct3,
    input  logic [63:0] in_pc,
    input  logic [63:0] in_rd1,
    input  logic [63:0] in_rd2,
    input  logic [63:0] in_imm,
    input  logic        in_pred_taken,
    output logic        done,
    output logic        taken,
    output logic [63:0] link_data,
    output logic        redirect_valid,
    output logic [63:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        flush,
    input  logic [63:0] pred_pc,
    output logic        pred_taken
);

    typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_REDIRECT} state_t;

    state_t      state;
    logic [1:0]  c_kind;
    logic [2:0]  c_funct3;
    logic [63:0] c_pc, c_rd1, c_rd2, c_imm;
    logic        c_pred;

    logic        is_jalr, is_jump, eq, lt, res_taken, predicted, need_redirect;
    logic [63:0] target, dest;

    assign in_ready = (state == S_IDLE);

    // Resolve the captured branch: outcome, target and redirect destination.
    always_comb begin
        is_jalr   = (c_kind == 2'b10);
        is_jump   = (c_kind == 2'b01) || is_jalr;
        eq        = (c_rd1 == c_rd2);
        lt        = c_funct3[1] ? (c_rd1 < c_rd2) : ($signed(c_rd1) < $signed(c_rd2));
        case (c_funct3)
            3'b000:          res_taken = eq;
            3'b001:          res_taken = !eq;
            3'b100, 3'b110:  res_taken = lt;
            3'b101, 3'b111:  res_taken = !lt;
            default:         res_taken = 1'b0;
        endcase
        if (is_jump) res_taken = 1'b1;
        target    = is_jalr ? ((c_rd1 + c_imm) & ~64'h1) : (c_pc + c_imm);
`ifdef BRANCH_PREDICT_EN
        predicted = c_pred;
`else
        predicted = 1'b0;
`endif
        need_redirect = is_jump || (res_taken != predicted);
        dest          = res_taken ? target : (c_pc + 64'd4);
    end

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            done           <= 1'b0;
            taken          <= 1'b0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            link_data      <= '0;
            c_kind         <= '0;
            c_funct3       <= '0;
            c_pc           <= '0;
            c_rd1          <= '0;
            c_rd2          <= '0;
            c_imm          <= '0;
            c_pred         <= 1'b0;
        end else begin
            done  <= 1'b0;
            flush <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        c_kind   <= in_kind;
                        c_funct3 <= in_funct3;
                        c_pc     <= in_pc;
                        c_rd1    <= in_rd1;
                        c_rd2    <= in_rd2;
                        c_imm    <= in_imm;
                        c_pred   <= in_pred_taken;
                        state    <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    done      <= 1'b1;
                    taken     <= res_taken;
                    link_data <= c_pc + 64'd4;
                    if (need_redirect) begin
                        redirect_valid <= 1'b1;
                        redirect_pc    <= dest;
                        flush          <= 1'b1;
                        state          <= S_REDIRECT;
                    end else begin
                        state <= S_IDLE;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        redirect_valid <= 1'b0;
                        state          <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef BRANCH_PREDICT_EN
    logic [1:0] bht [32];
    logic [1:0] upd_cnt;
    logic       unused_pc;

    assign unused_pc  = ^{pred_pc[63:7], pred_pc[1:0]};
    assign pred_taken = bht[pred_pc[6:2]][1];
    assign upd_cnt    = bht[c_pc[6:2]];

    // Train the counter of a conditional branch as it leaves COMPARE.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) bht[i] <= 2'b01;
        end else if (state == S_COMPARE && !is_jump) begin
            if (res_taken && upd_cnt != 2'b11)
                bht[c_pc[6:2]] <= upd_cnt + 2'b01;
            else if (!res_taken && upd_cnt != 2'b00)
                bht[c_pc[6:2]] <= upd_cnt - 2'b01;
        end
    end
`else
    logic unused_pred;

    // Without a table the fetch-side prediction and lookup PC have no effect.
    assign unused_pred = c_pred ^ (^pred_pc);
    assign pred_taken  = 1'b0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed bench with a transaction-level reference model
// checked every cycle, plus literal expectations for the listed scenarios.
module tb_branch_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_kind = '0;
    logic [2:0]  in_funct3 = '0;
    logic [63:0] in_pc = '0, in_rd1 = '0, in_rd2 = '0, in_imm = '0;
    logic        in_pred_taken = 1'b0;
    logic        done, taken, redirect_valid, flush, pred_taken;
    logic [63:0] link_data, redirect_pc;
    logic        redirect_ready = 1'b1;
    logic [63:0] pred_pc = 64'h8000_0040;

    int checks = 0;
    int failures = 0;

    branch_ctrl dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_funct3(in_funct3), .in_pc(in_pc), .in_rd1(in_rd1),
        .in_rd2(in_rd2), .in_imm(in_imm), .in_pred_taken(in_pred_taken),
        .done(done), .taken(taken), .link_data(link_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .redirect_ready(redirect_ready), .flush(flush),
        .pred_pc(pred_pc), .pred_taken(pred_taken)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
`ifdef BRANCH_PREDICT_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif
    bit          checking = 0;
    bit          pend = 0;
    bit          m_done = 0, m_taken = 0, m_rv = 0, m_flush = 0;
    logic [63:0] m_link = '0, m_rpc = '0;
    logic [1:0]  p_kind;
    logic [2:0]  p_f3;
    logic [63:0] p_pc, p_a, p_b, p_imm;
    bit          p_pt;
    int          cnt [32];

    task automatic resolve();
        bit jump, t, pred, redir;
        logic [63:0] tgt;
        jump = (p_kind == 2'd1) || (p_kind == 2'd2);
        case (p_f3)
            3'd0: t = (p_a == p_b);
            3'd1: t = (p_a != p_b);
            3'd4: t = ($signed(p_a) < $signed(p_b));
            3'd5: t = !($signed(p_a) < $signed(p_b));
            3'd6: t = (p_a < p_b);
            3'd7: t = !(p_a < p_b);
            default: t = 0;
        endcase
        if (jump) t = 1;
        tgt  = (p_kind == 2'd2) ? ((p_a + p_imm) & ~64'h1) : (p_pc + p_imm);
        pred = BP ? p_pt : 1'b0;
        redir = jump || (t != pred);
        m_done  = 1;
        m_taken = t;
        m_link  = p_pc + 64'd4;
        if (redir) begin
            m_rv = 1; m_flush = 1;
            m_rpc = t ? tgt : p_pc + 64'd4;
        end
        if (BP && !jump) begin
            if (t) cnt[p_pc[6:2]] = (cnt[p_pc[6:2]] < 3) ? cnt[p_pc[6:2]] + 1 : 3;
            else   cnt[p_pc[6:2]] = (cnt[p_pc[6:2]] > 0) ? cnt[p_pc[6:2]] - 1 : 0;
        end
    endtask

    always @(posedge clk) begin
        bit was_ready;
        if (reset) begin
            checking = 1;
            pend = 0; m_done = 0; m_taken = 0; m_rv = 0; m_flush = 0;
            m_link = '0; m_rpc = '0;
            for (int i = 0; i < 32; i++) cnt[i] = 1;
        end else begin
            was_ready = !pend && !m_rv;
            m_done = 0; m_flush = 0;
            if (pend) begin
                resolve();
                pend = 0;
            end else if (m_rv && redirect_ready) begin
                m_rv = 0;
            end
            if (was_ready && in_valid) begin
                p_kind = in_kind; p_f3 = in_funct3; p_pc = in_pc;
                p_a = in_rd1; p_b = in_rd2; p_imm = in_imm; p_pt = in_pred_taken;
                pend = 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (checking) begin
            chk("m_in_ready", in_ready, !pend && !m_rv);
            chk("m_done", done, m_done);
            chk("m_flush", flush, m_flush);
            chk("m_redirect_valid", redirect_valid, m_rv);
            chk("m_pred_taken", pred_taken, BP ? cnt[pred_pc[6:2]] >= 2 : 0);
            if (m_done) begin
                chk("m_taken", taken, m_taken);
                chk("m_link_data", link_data, m_link);
            end
            if (m_rv) chk("m_redirect_pc", redirect_pc, m_rpc);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [1:0] k, input logic [2:0] f3, input logic [63:0] pc,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] imm,
                         input logic pt);
        @(posedge clk); #2;
        in_kind = k; in_funct3 = f3; in_pc = pc; in_rd1 = a; in_rd2 = b;
        in_imm = imm; in_pred_taken = pt; in_valid = 1'b1;
        chk("accept_ready", in_ready, 1'b1);
        @(posedge clk); #2;
        in_valid = 1'b0;
    endtask

    // Move to cycle N+2 of the most recent issue.
    task automatic to_n2();
        @(posedge clk); #2;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #4;
            n++;
        end
        if (!in_ready) begin
            failures++;
            $display("FAIL wait_idle timeout in_ready=%0b exp=1", in_ready);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

    initial begin
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        #2;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_taken", taken, 0);
        chk("rst_redirect_valid", redirect_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_pred_taken", pred_taken, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_link_data", link_data, 0);

        // BEQ taken -> redirect to pc+imm
        issue(2'd0, 3'b000, 64'h8000_0000, 64'd5, 64'd5, 64'h10, 0);
        to_n2();
        chk("beq_done", done, 1);
        chk("beq_taken", taken, 1);
        chk("beq_rv", redirect_valid, 1);
        chk("beq_rpc", redirect_pc, 64'h8000_0010);
        chk("beq_flush", flush, 1);
        chk("beq_link", link_data, 64'h8000_0004);
        wait_idle();

        // BLT signed: -1 < 1 taken
        issue(2'd0, 3'b100, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 0);
        to_n2();
        chk("blt_taken", taken, 1);
        chk("blt_rv", redirect_valid, 1);
        chk("blt_rpc", redirect_pc, 64'h8000_0120);
        wait_idle();

        // BLTU: max unsigned not < 1
        issue(2'd0, 3'b110, 64'h8000_0100, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h20, 0);
        to_n2();
        chk("bltu_done", done, 1);
        chk("bltu_taken", taken, 0);
        chk("bltu_rv", redirect_valid, 0);
        chk("bltu_flush", flush, 0);
        chk("bltu_in_ready", in_ready, 1);

        // JALR clears bit 0 of rd1+imm
        issue(2'd2, 3'b000, 64'h8000_0200, 64'h8000_0103, 64'd0, 64'd4, 0);
        to_n2();
        chk("jalr_rpc", redirect_pc, 64'h8000_0106);
        chk("jalr_taken", taken, 1);
        chk("jalr_link", link_data, 64'h8000_0204);
        wait_idle();

        // Held redirect: BNE backward to 0xFF8 with fetch stalled
        redirect_ready = 1'b0;
        issue(2'd0, 3'b001, 64'h1000, 64'd1, 64'd2, 64'hFFFF_FFFF_FFFF_FFF8, 0);
        to_n2();
        chk("hold_flush_n2", flush, 1);
        chk("hold_rpc_n2", redirect_pc, 64'hFF8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #2;
            chk("hold_rv", redirect_valid, 1);
            chk("hold_rpc", redirect_pc, 64'hFF8);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_flush", flush, 0);
        end
        redirect_ready = 1'b1;
        @(posedge clk); #2;
        chk("hold_release_idle", in_ready, 1);
        chk("hold_release_rv", redirect_valid, 0);

        // Odd kind/funct3 encodings
        issue(2'd3, 3'b000, 64'h3000, 64'd7, 64'd7, 64'h40, 0);
        to_n2();
        chk("kind11_rpc", redirect_pc, 64'h3040);
        wait_idle();
        issue(2'd0, 3'b010, 64'h3000, 64'd7, 64'd7, 64'h40, 0);
        to_n2();
        chk("f3_010_taken", taken, 0);
        chk("f3_010_rv", redirect_valid, 0);

        // Back-to-back not-taken branches, 2-cycle spacing
        issue(2'd0, 3'b001, 64'h4000, 64'd9, 64'd9, 64'h8, 0);
        issue(2'd0, 3'b101, 64'h4004, 64'd1, 64'd2, 64'h8, 0);
        to_n2();
        chk("b2b_done", done, 1);
        chk("b2b_link", link_data, 64'h4008);
        chk("b2b_rv", redirect_valid, 0);

        // Reset while in REDIRECT drops the redirect
        redirect_ready = 1'b0;
        issue(2'd1, 3'b000, 64'h2000, 64'd0, 64'd0, 64'h100, 0);
        to_n2();
        chk("jal_rpc", redirect_pc, 64'h2100);
        reset = 1'b1;
        @(posedge clk); #2;
        chk("midrst_rv", redirect_valid, 0);
        chk("midrst_flush", flush, 0);
        chk("midrst_in_ready", in_ready, 1);
        reset = 1'b0;
        redirect_ready = 1'b1;
        issue(2'd0, 3'b001, 64'h5000, 64'd3, 64'd4, 64'h10, 0);
        to_n2();
        chk("post_rst_bne_done", done, 1);
        chk("post_rst_bne_rpc", redirect_pc, 64'h5010);
        wait_idle();

`ifdef BRANCH_PREDICT_EN
        pred_pc = 64'h8000_0040;
        #1;
        chk("bp_initial", pred_taken, 0);
        issue(2'd0, 3'b001, 64'h8000_0040, 64'd1, 64'd2, 64'h20, 0);
        to_n2();
        chk("bp_first_rv", redirect_valid, 1);
        chk("bp_after_first", pred_taken, 1);
        wait_idle();
        issue(2'd0, 3'b001, 64'h8000_0040, 64'd1, 64'd2, 64'h20, 1);
        to_n2();
        wait_idle();
        issue(2'd0, 3'b001, 64'h8000_0040, 64'd1, 64'd2, 64'h20, 1);
        to_n2();
        chk("bp_third_done", done, 1);
        chk("bp_third_rv", redirect_valid, 0);
        chk("bp_third_flush", flush, 0);
        wait_idle();
        issue(2'd0, 3'b001, 64'h8000_0040, 64'd2, 64'd2, 64'h20, 1);
        to_n2();
        chk("bp_mispred_rv", redirect_valid, 1);
        chk("bp_mispred_rpc", redirect_pc, 64'h8000_0044);
        wait_idle();
`else
        // Without prediction a taken branch redirects even if predicted taken
        issue(2'd0, 3'b001, 64'h8000_0040, 64'd1, 64'd2, 64'h20, 1);
        to_n2();
        chk("nobp_rv", redirect_valid, 1);
        chk("nobp_pred_taken", pred_taken, 0);
        wait_idle();
`endif

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_ctrl.md
# branch_ctrl

Execute-stage branch resolution controller for the RV64 pipeline. It accepts one branch or jump at a time from the execute stage and sequences a signed/unsigned operand comparison. It decides the outcome and target, and drives a held redirect/flush handshake toward fetch until fetch accepts it. An optional 2-bit branch history table supplies fetch-side predictions and suppresses redirects for correctly predicted conditional branches.

## Interface
- No parameters; table size is fixed at 32 entries.
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  execute stage presents a branch/jump.
- in_ready  out  1  controller can accept; high only in IDLE.
- in_kind  in  2  00 conditional branch, 01 JAL, 10 JALR; 11 is treated as 00.
- in_funct3  in  3  BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; others are never taken.
- in_pc, in_rd1, in_rd2, in_imm  in  64 each  instruction PC, rs1 value, rs2 value, sign-extended immediate.
- in_pred_taken  in  1  fetch-time prediction carried down the pipe.
- done  out  1  one-cycle pulse when resolution completes.
- taken  out  1  resolved outcome; valid while done=1.
- link_data  out  64  in_pc+4; valid while done=1.
- redirect_valid  out  1  redirect request to fetch.
- redirect_pc  out  64  redirect target.
- redirect_ready  in  1  fetch accepts the redirect.
- flush  out  1  one-cycle pulse that kills younger instructions.
- pred_pc  in  64  fetch lookup PC.
- pred_taken  out  1  combinational prediction for pred_pc.

## Operation
- The controller has three states: IDLE, COMPARE and REDIRECT.
- **IDLE**
  - in_ready=1.
  - On in_valid, the controller captures all in_* fields and moves to COMPARE.
- **COMPARE** (exactly one cycle)
  - Comparison:
    - eq is rs1==rs2 over all 64 bits.
    - lt is unsigned when funct3[1]=1, signed otherwise.
    - BEQ=eq, BNE=!eq, BLT/BLTU=lt, BGE/BGEU=!lt.
    - JAL and JALR are always taken.
  - Target, with 64-bit wrap-around addition and no overflow detection:
    - JALR: (rd1+imm) with bit 0 cleared.
    - Otherwise: pc+imm.
  - Required redirect and its destination:
    - JAL/JALR: always redirect, to the target.
    - Conditional branch: redirect when taken != predicted.
      - Taken: redirect to the target.
      - Not taken: redirect to pc+4.
    - The predicted value is the one defined in Configuration.
  - Next state: REDIRECT if a redirect is needed, else IDLE.
- **REDIRECT**
  - redirect_valid=1; redirect_pc holds stable.
  - Moves to IDLE in the cycle redirect_ready=1.
- Outputs done, taken, link_data, redirect_pc and flush are registered.
- **Reset values:** state=IDLE, with done, taken, flush, redirect_valid and pred_taken all 0. redirect_pc, link_data and captured fields are 0. All table counters are 01.
- **Reset mid-operation:** reset in any state returns to IDLE next cycle. A pending redirect is dropped and no flush is issued.

## Timing
- Handshake accepted at the end of cycle N; COMPARE is cycle N+1.
- Cycle N+2:
  - done=1 and taken and link_data are valid.
  - If a redirect is needed: redirect_valid=1 and flush=1, in the same cycle.
  - If no redirect: state is IDLE and in_ready=1, so a new branch can be accepted in N+2.
- Minimum accept-to-accept spacing:
  - 2 cycles without a redirect.
  - 3 cycles with a redirect and redirect_ready=1 in N+2.
- flush pulses exactly once per redirect, regardless of how long redirect_ready stays low.
- in_ready=0 throughout COMPARE and REDIRECT; in_valid is ignored there.

## Configuration
- **BRANCH_PREDICT_EN defined:**
  - 32-entry table of 2-bit saturating counters, indexed by pc[6:2].
  - pred_taken = counter[pred_pc[6:2]][1].
  - Predicted value = in_pred_taken.
  - At the end of COMPARE, the controller updates only conditional-branch entries: taken increments toward 11, not-taken decrements toward 00.
  - A lookup in the same cycle as an update returns the old value.
- **BRANCH_PREDICT_EN undefined:**
  - No table; pred_taken is tied to 0.
  - in_pred_taken is ignored and the predicted value is always 0.
  - Every taken branch redirects.

## Test plan
- BEQ, rd1=rd2=5, pc=0x80000000, imm=0x10, accepted at N:
  - N+2: done=1, taken=1, redirect_valid=1, redirect_pc=0x80000010, flush=1, link_data=0x80000004.
- BLT with rd1=0xFFFFFFFFFFFFFFFF, rd2=1 -> taken, redirect.
- BLTU with the same operands:
  - taken=0, done=1, no redirect or flush.
  - in_ready=1 at N+2.
- JALR with rd1=0x80000103, imm=4:
  - redirect_pc=0x80000106, taken=1.
  - pc=0x80000200 gives link_data=0x80000204.
- redirect_ready held low 3 cycles after the N+2 redirect:
  - redirect_valid and redirect_pc stay stable and in_ready stays 0.
  - flush is high only in N+2.
  - IDLE the cycle after redirect_ready=1.
- Reset asserted in REDIRECT:
  - Next cycle redirect_valid=0, flush=0, in_ready=1.
  - A new BNE is accepted normally afterwards.
- With BRANCH_PREDICT_EN, repeated taken BNE at pc=0x80000040:
  - pred_pc=0x80000040: pred_taken=0 initially, 1 after the first update.
  - Third issue with in_pred_taken=1 and taken: no redirect.
  - Then not taken with in_pred_taken=1: redirect to 0x80000044.
